ssd4_scan_driver: RTL and testbench

SSD4_SCAN_DRIVER -- requirements
Module: ssd4_scan_driver

---
 rtl/ssd4_scan_driver_if.sv | 9 +
 rtl/ssd4_scan_driver.sv | 68 ++++++
 tb/tb_ssd4_scan_driver.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/ssd4_scan_driver_if.sv
// Digit data in, multiplexed segment/select drive out, for the 4-digit scan driver.
interface ssd4_scan_driver_if;
    logic [19:0] fields;
    logic [7:0]  seg;
    logic [3:0]  sel;

    modport master (output fields, input seg, input sel);
    modport slave  (input fields, output seg, output sel);
endinterface

// File: rtl/ssd4_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display with decimal points.
module ssd4_scan_driver #(
    parameter int unsigned COUNT_TO = 10000
) (
    input logic               clk,
    input logic               rst_n,
    ssd4_scan_driver_if.slave bus
);
    localparam logic [31:0] LAST = 32'(COUNT_TO - 32'd1);

    logic [31:0] cnt;
    logic [1:0]  idx;
    logic        tick;
    logic [4:0]  field;

    assign tick = (cnt == LAST);

    always_comb begin
        field = bus.fields[4:0];
        unique case (idx)
            2'd0: field = bus.fields[4:0];
            2'd1: field = bus.fields[9:5];
            2'd2: field = bus.fields[14:10];
            2'd3: field = bus.fields[19:15];
        endcase
    end

    // Active-low g..a.
    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] s;
        unique case (hex)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Outputs load only on the scan tick, so input activity between ticks is invisible.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt     <= 32'd0;
            idx     <= 2'd0;
            bus.sel <= 4'hF;
            bus.seg <= 8'hFF;
        end else if (tick) begin
            cnt     <= 32'd0;
            idx     <= idx + 2'd1;
            bus.sel <= ~(4'b0001 << idx);
            bus.seg <= {field[4], decode(field[3:0])};
        end else begin
            cnt <= cnt + 32'd1;
        end
    end
endmodule

// File: tb/tb_ssd4_scan_driver.sv
// Bench for ssd4_scan_driver: scan-step instance (COUNT_TO=4) under a tick-model scoreboard, plus a COUNT_TO=1 instance.
module tb_ssd4_scan_driver;
    localparam int CT = 4;

    typedef struct {
        logic [19:0] fields;
        logic [3:0]  sel;
        logic [7:0]  seg;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic [19:0] fields;
    logic        mon_en;
    int          mcnt;
    int          n_vec;
    int          n_err;
    logic [3:0]  held_sel;
    logic [7:0]  held_seg;
    logic [11:0] mon_e;
    logic [11:0] sb_q[$];
    vec_t        vecs[69];
    logic [6:0]  seg_lut[16];

    ssd4_scan_driver_if bus4 ();
    ssd4_scan_driver_if bus1 ();
    assign bus4.fields = fields;
    assign bus1.fields = fields;

    ssd4_scan_driver #(.COUNT_TO(CT)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
    ssd4_scan_driver #(.COUNT_TO(1))  dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_for(input logic [19:0] f, input int idx);
        logic [4:0] fld;
        fld = f[5*idx +: 5];
        return {~(4'b0001 << idx), fld[4], seg_lut[fld[3:0]]};
    endfunction

    // Ends on a falling edge after n rising edges.
    task automatic wait_edges(input int n);
        repeat (n) @(posedge clk);
        @(negedge clk);
    endtask

    // Independent tick model: every CT-th edge after reset release pops one expectation.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (!mon_en) continue;
            if (!rst_n) begin
                mcnt = 0;
                chk("hold_sel_rst", bus4.sel, held_sel);
                chk("hold_seg_rst", bus4.seg, held_seg);
            end else if (mcnt == CT - 1) begin
                mcnt = 0;
                if (sb_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL sb_underflow: tick with no expectation at %0t", $time);
                end else begin
                    mon_e = sb_q.pop_front();
                    chk("tick_sel", bus4.sel, mon_e[11:8]);
                    chk("tick_seg", bus4.seg, mon_e[7:0]);
                    held_sel = mon_e[11:8];
                    held_seg = mon_e[7:0];
                end
            end else begin
                mcnt++;
                chk("hold_sel", bus4.sel, held_sel);
                chk("hold_seg", bus4.seg, held_seg);
            end
        end
    end

    initial begin
        logic [19:0] fa;
        logic [19:0] fb;
        logic [11:0] e;
        logic [4:0]  f5;

        seg_lut = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        fa = {5'b10011, 5'b10010, 5'b00001, 5'b10000};
        vecs[0] = '{fa, 4'b1110, 8'hC0};
        vecs[1] = '{fa, 4'b1101, 8'h79};
        vecs[2] = '{fa, 4'b1011, 8'hA4};
        vecs[3] = '{fa, 4'b0111, 8'hB0};
        vecs[4] = '{fa, 4'b1110, 8'hC0};
        for (int v = 0; v < 16; v++) begin
            f5 = {1'b1, 4'(v)};
            for (int s = 0; s < 4; s++) begin
                automatic int k = 5 + v * 4 + s;
                vecs[k] = '{{f5, f5, f5, f5}, ~(4'b0001 << (k % 4)), {1'b1, seg_lut[v]}};
            end
        end

        n_vec = 0;
        n_err = 0;
        mcnt = 0;
        mon_en = 1'b0;
        held_sel = 4'hF;
        held_seg = 8'hFF;
        fields = 20'h0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_sel4", bus4.sel, 4'hF);
        chk("reset_seg4", bus4.seg, 8'hFF);
        chk("reset_sel1", bus1.sel, 4'hF);
        chk("reset_seg1", bus1.seg, 8'hFF);

        mon_en = 1'b1;
        rst_n = 1'b1;
        for (int i = 0; i < 69; i++) begin
            fields = vecs[i].fields;
            sb_q.push_back({vecs[i].sel, vecs[i].seg});
            wait_edges(4);
        end

        // Digit 1: input changes two cycles before the tick and the new value is shown.
        fa = {5'h10, 5'h10, 5'h10, 5'h10};
        fb = {5'h0A, 5'h0A, 5'h0A, 5'h0A};
        fields = fa;
        wait_edges(2);
        fields = fb;
        sb_q.push_back(exp_for(fb, 1));
        wait_edges(2);

        // Digit 2: a glitch that reverts before the tick has no effect.
        fa = {5'h1E, 5'h1E, 5'h1E, 5'h1E};
        fb = {5'h05, 5'h05, 5'h05, 5'h05};
        fields = fa;
        sb_q.push_back(exp_for(fa, 2));
        wait_edges(1);
        fields = fb;
        wait_edges(1);
        fields = fa;
        wait_edges(2);

        // Reset while digit 2 is lit: blanks without any clock edge.
        #2;
        rst_n = 1'b0;
        mcnt = 0;
        held_sel = 4'hF;
        held_seg = 8'hFF;
        #1;
        chk("async_rst_sel", bus4.sel, 4'hF);
        chk("async_rst_seg", bus4.seg, 8'hFF);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        fa = {5'h17, 5'h0C, 5'h1B, 5'h09};
        fields = fa;
        sb_q.push_back(exp_for(fa, 0));
        wait_edges(4);
        sb_q.push_back(exp_for(fa, 1));
        wait_edges(4);
        mon_en = 1'b0;
        chk("sb_drain", sb_q.size(), 0);

        // COUNT_TO=1: select rotates every cycle, first digit 0 on the first edge.
        fa = {5'h1D, 5'h04, 5'h16, 5'h0F};
        fields = fa;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ct1_rst_sel", bus1.sel, 4'hF);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk);
            #1;
            e = exp_for(fa, k % 4);
            chk("ct1_sel", bus1.sel, e[11:8]);
            chk("ct1_seg", bus1.seg, e[7:0]);
            chk("ct1_onecold", $countones(~bus1.sel), 1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
